yarvi_loader: RTL

- Serial boot loader on the write side of the fetch unit's code memory.
- Consumes a byte stream (e.g. from a UART receiver) and parses framed commands.
- Drives word writes onto the code-memory write port (address / writedata / writemask).
- On a GO command, issues a one-cycle restart with a new PC.

---
 rtl/yarvi_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/yarvi_loader.sv
// Serial boot loader: parses framed byte commands into code-memory word writes
// and a one-cycle fetch restart with a new PC.
`ifndef VMSB
`define VMSB 31
`endif

module yarvi_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [`VMSB:2]    address,
    output logic [31:0]       writedata,
    output logic [3:0]        writemask,
    output logic              restart,
    output logic [`VMSB:0]    restart_pc,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CMD,
        ST_ADDR,
        ST_COUNT,
        ST_DATA,
        ST_GO_ADDR,
        ST_GO_PULSE
    } state_t;

    state_t            state, state_d;
    logic [1:0]        byte_cnt;
    logic [23:0]       shreg;
    logic [31:0]       asm_word;
    logic [`VMSB:2]    word_addr;
    logic [15:0]       remaining;
    logic [TW-1:0]     tcount;

    logic accept, collecting, timed, timed_out, last_lane;
    logic err_inc, addr_load, cnt_load, word_wr, pc_load;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready   = (state != ST_GO_PULSE);
    assign busy       = (state != ST_SYNC);
    assign accept     = in_valid && in_ready;
    // Little-endian assembly: the newest byte always lands in the top lane.
    assign asm_word   = {in_data, shreg};
    assign last_lane  = (byte_cnt == 2'd3);
    assign collecting = state inside {ST_ADDR, ST_COUNT, ST_DATA, ST_GO_ADDR};
    assign timed      = state inside {ST_CMD, ST_ADDR, ST_COUNT, ST_DATA, ST_GO_ADDR};
    assign timed_out  = timed && !accept && (tcount == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_SYNC;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        err_inc   = 1'b0;
        addr_load = 1'b0;
        cnt_load  = 1'b0;
        word_wr   = 1'b0;
        pc_load   = 1'b0;
        case (state)
            ST_SYNC: begin
                if (accept && in_data == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (accept) begin
                    if (in_data == 8'h01)      state_d = ST_ADDR;
                    else if (in_data == 8'h02) state_d = ST_GO_ADDR;
                    else begin
                        err_inc = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
            end
            ST_ADDR: begin
                if (accept && last_lane) begin
                    addr_load = 1'b1;
                    state_d   = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (accept && byte_cnt == 2'd1) begin
                    if (asm_word[31:16] == 16'd0) state_d = ST_SYNC;
                    else begin
                        cnt_load = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && last_lane) begin
                    word_wr = 1'b1;
                    if (remaining == 16'd1) state_d = ST_SYNC;
                end
            end
            ST_GO_ADDR: begin
                if (accept && last_lane) begin
                    pc_load = 1'b1;
                    state_d = ST_GO_PULSE;
                end
            end
            ST_GO_PULSE: state_d = ST_SYNC;
            default:     state_d = ST_SYNC;
        endcase
        // timed_out already excludes an accepted byte, so the byte wins a tie.
        if (timed_out) begin
            err_inc = 1'b1;
            state_d = ST_SYNC;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= 2'd0;
            shreg      <= 24'd0;
            word_addr  <= '0;
            remaining  <= 16'd0;
            tcount     <= '0;
            address    <= '0;
            writedata  <= 32'd0;
            writemask  <= 4'h0;
            restart    <= 1'b0;
            restart_pc <= '0;
            err_count  <= 8'd0;
        end else begin
            writemask <= 4'h0;
            restart   <= 1'b0;

            if (err_inc) err_count <= sat_inc(err_count);

            if (state_d != state)          byte_cnt <= 2'd0;
            else if (accept && collecting) byte_cnt <= byte_cnt + 2'd1;

            if (accept) shreg <= asm_word[31:8];

            if (accept || !timed || timed_out) tcount <= '0;
            else                               tcount <= tcount + TW'(1);

            if (addr_load) word_addr <= asm_word[`VMSB:2];
            if (cnt_load)  remaining <= asm_word[31:16];

            if (word_wr) begin
                writemask <= 4'hF;
                writedata <= asm_word;
                address   <= word_addr;
                word_addr <= word_addr + {{(`VMSB - 2){1'b0}}, 1'b1};
                remaining <= remaining - 16'd1;
            end

            if (pc_load) begin
                restart    <= 1'b1;
                restart_pc <= {asm_word[`VMSB:2], 2'b00};
            end
        end
    end

endmodule
